lfsr_multi: RTL

- Parametrised Galois LFSR for the custom 8-bit system; the next generation of the basic single-step LFSR.
- Adds runtime-programmable taps and a variable number of shifts per cycle (1..STEPS).
- Adds zero-lockup protection on seed load and a "draw" handshake that returns a fully re-mixed LEN-bit word.
- Serves the starfield, noise and game-logic random sources.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_multi.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and types for the multi-step Galois LFSR.
// Holds default maximal-length taps, draw FSM encoding and the step-port width helper.
package lfsr_pkg;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  function automatic int step_w(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR step: shift right, fold taps in when the outgoing bit is set.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int LEN = 16
) (
  input  logic [LEN-1:0] i_s,
  input  logic [LEN-1:0] i_taps,
  output logic [LEN-1:0] o_s
);

  assign o_s = {1'b0, i_s[LEN-1:1]} ^ (i_s[0] ? i_taps : '0);

endmodule

// File: rtl/lfsr_multi.sv
// Galois LFSR with programmable taps, 1..STEPS shifts per cycle, zero-seed protection
// and a draw handshake that returns a word re-mixed by ceil(LEN/STEPS) full-width advances.
module lfsr_multi
  import lfsr_pkg::*;
#(
  parameter int             LEN      = 16,
  parameter int             STEPS    = 4,
  parameter logic [LEN-1:0] TAPS     = TAPS_16,
  parameter logic [LEN-1:0] SEED_RST = {{(LEN-1){1'b0}}, 1'b1}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_load,
  input  logic [LEN-1:0]             seed,
  input  logic                       taps_we,
  input  logic [LEN-1:0]             taps_in,
  input  logic                       en,
  input  logic [step_w(STEPS)-1:0]   step,
  input  logic                       draw_req,
  output logic                       busy,
  output logic [LEN-1:0]             word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [LEN-1:0]             sreg,
  output logic [LEN-1:0]             taps,
  output logic                       lock_fix
);

  localparam int               STEP_W   = step_w(STEPS);
  localparam int               N_DRAW   = (LEN + STEPS - 1) / STEPS;
  localparam int               CNT_W    = (N_DRAW > 1) ? $clog2(N_DRAW) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_DRAW - 1);
  localparam logic [STEP_W-1:0] STEPS_V = STEP_W'(STEPS);
  localparam logic [LEN-1:0]   TAP_MSB  = {1'b1, {(LEN-1){1'b0}}};

  state_t           r_state, w_state_next;
  logic [LEN-1:0]   r_sreg, w_sreg_next;
  logic [LEN-1:0]   r_taps;
  logic [LEN-1:0]   r_word, w_word_next;
  logic             r_word_valid, w_valid_next;
  logic             r_lock_fix;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic [LEN-1:0]    w_chain [STEPS+1];
  logic [STEP_W-1:0] w_en_shift;

  // Tap point k of the chain is the state advanced by k single steps.
  assign w_chain[0] = r_sreg;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_chain
      lfsr_step #(.LEN(LEN)) u_step (
        .i_s    (w_chain[gi]),
        .i_taps (r_taps),
        .o_s    (w_chain[gi+1])
      );
    end
  endgenerate

  assign w_en_shift = (step > STEPS_V) ? STEPS_V : step;

  always_comb begin
    w_state_next = r_state;
    w_sreg_next  = r_sreg;
    w_word_next  = r_word;
    w_valid_next = r_word_valid;
    w_cnt_next   = r_cnt;
    if (seed_load) begin
      w_sreg_next  = (seed == '0) ? SEED_RST : seed;
      w_state_next = ST_IDLE;
      w_valid_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) w_sreg_next = w_chain[w_en_shift];
          if (draw_req) begin
            w_state_next = ST_SHIFT;
            w_cnt_next   = CNT_INIT;
          end
        end
        ST_SHIFT: begin
          w_sreg_next = w_chain[STEPS];
          if (r_cnt == '0) begin
            w_word_next  = w_chain[STEPS];
            w_valid_next = 1'b1;
            w_state_next = ST_VALID;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        ST_VALID: begin
          if (en) w_sreg_next = w_chain[w_en_shift];
          if (word_ready) begin
            w_valid_next = 1'b0;
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sreg       <= SEED_RST;
      r_taps       <= TAPS | TAP_MSB;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_lock_fix   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sreg       <= w_sreg_next;
      r_word       <= w_word_next;
      r_word_valid <= w_valid_next;
      r_cnt        <= w_cnt_next;
      r_lock_fix   <= seed_load && (seed == '0);
      // Forcing the MSB tap keeps the step invertible, so nonzero states never collapse to zero.
      if (taps_we) r_taps <= taps_in | TAP_MSB;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign sreg       = r_sreg;
  assign taps       = r_taps;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign lock_fix   = r_lock_fix;

endmodule
